// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: one outstanding request to a handshaked instruction memory,
// a 1-entry skid buffer behind the F/D slot, and execute-stage redirect with in-flight kill.
module fetch_sequencer #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_d,
    input  logic             i_redirect_e,
    input  logic [WIDTH-1:0] i_redirect_pc_e,
    output logic             o_imem_req_valid,
    input  logic             i_imem_req_ready,
    output logic [WIDTH-1:0] o_imem_req_addr,
    input  logic             i_imem_resp_valid,
    input  logic [31:0]      i_imem_resp_data,
    output logic [31:0]      o_instr_f,
    output logic [WIDTH-1:0] o_pc_f,
    output logic [WIDTH-1:0] o_pc_plus4_f,
    output logic             o_instr_valid_f
);

    // state | meaning
    // IDLE  | post-reset bubble; REQ next cycle
    // REQ   | request for r_pc presented to memory
    // WAIT  | one request outstanding, waiting for its response
    // HOLD  | response parked in skid buffer until the F/D slot frees up
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_pc, w_pc;
    logic [WIDTH-1:0] r_pc_inflight, w_pc_inflight;
    logic             r_kill, w_kill;
    logic             r_skid_valid, w_skid_valid;
    logic [31:0]      r_skid_instr, w_skid_instr;
    logic [WIDTH-1:0] r_skid_pc, w_skid_pc;
    logic             r_slot_valid, w_slot_valid;
    logic [31:0]      r_slot_instr, w_slot_instr;
    logic [WIDTH-1:0] r_slot_pc, w_slot_pc;

    logic             w_req_fire;
    logic             w_slot_free;

    assign w_req_fire  = (r_state == REQ) && i_imem_req_ready;
    assign w_slot_free = !r_slot_valid || !i_stall_d;

    always_comb begin
        w_state          = r_state;
        w_pc             = r_pc;
        w_pc_inflight    = r_pc_inflight;
        w_kill           = r_kill;
        w_skid_valid     = r_skid_valid;
        w_skid_instr     = r_skid_instr;
        w_skid_pc        = r_skid_pc;
        // a consumed slot empties unless something is loaded below
        w_slot_valid     = r_slot_valid && i_stall_d;
        w_slot_instr     = r_slot_instr;
        w_slot_pc        = r_slot_pc;
        o_imem_req_valid = 1'b0;

        case (r_state)
            IDLE: w_state = REQ;
            REQ: begin
                o_imem_req_valid = 1'b1;
                if (w_req_fire) begin
                    w_pc_inflight = r_pc;
                    w_pc          = r_pc + PC_STEP;
                    w_state       = WAIT;
                end
            end
            WAIT: begin
                if (i_imem_resp_valid) begin
                    if (r_kill) begin
                        w_kill  = 1'b0;
                        w_state = REQ;
                    end else if (w_slot_free) begin
                        w_slot_valid = 1'b1;
                        w_slot_instr = i_imem_resp_data;
                        w_slot_pc    = r_pc_inflight;
                        w_state      = REQ;
                    end else begin
                        w_skid_valid = 1'b1;
                        w_skid_instr = i_imem_resp_data;
                        w_skid_pc    = r_pc_inflight;
                        w_state      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_slot_free) begin
                    w_slot_valid = 1'b1;
                    w_slot_instr = r_skid_instr;
                    w_slot_pc    = r_skid_pc;
                    w_skid_valid = 1'b0;
                    w_state      = REQ;
                end
            end
            default: w_state = IDLE;
        endcase

        // redirect overrides everything above, including a same-cycle response
        if (i_redirect_e) begin
            w_pc         = {i_redirect_pc_e[WIDTH-1:2], 2'b00};
            w_slot_valid = 1'b0;
            w_skid_valid = 1'b0;
            case (r_state)
                REQ: begin
                    if (w_req_fire) begin
                        w_kill  = 1'b1;
                        w_state = WAIT;
                    end else begin
                        w_state = REQ;
                    end
                end
                WAIT: begin
                    if (i_imem_resp_valid) begin
                        w_kill  = 1'b0;
                        w_state = REQ;
                    end else begin
                        w_kill  = 1'b1;
                        w_state = WAIT;
                    end
                end
                default: w_state = REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_pc_inflight <= '0;
            r_kill        <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_slot_valid  <= 1'b0;
            r_slot_instr  <= '0;
            r_slot_pc     <= '0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_pc_inflight <= w_pc_inflight;
            r_kill        <= w_kill;
            r_skid_valid  <= w_skid_valid;
            r_skid_instr  <= w_skid_instr;
            r_skid_pc     <= w_skid_pc;
            r_slot_valid  <= w_slot_valid;
            r_slot_instr  <= w_slot_instr;
            r_slot_pc     <= w_slot_pc;
        end
    end

    assign o_imem_req_addr = r_pc;
    assign o_instr_f       = r_slot_instr;
    assign o_pc_f          = r_slot_pc;
    assign o_pc_plus4_f    = r_slot_pc + PC_STEP;
    assign o_instr_valid_f = r_slot_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory model with programmable latency, and
// scoreboards of expected request addresses and consumed F/D-slot instructions.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_d = 1'b0;
    logic        redirect_e = 1'b0;
    logic [31:0] redirect_pc_e = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        instr_valid_f;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;
    int lat     = 1;
    int cons_last = 0;
    int cons_prev = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_cons[$];
    logic [31:0] mon_e;

    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall_d        (stall_d),
        .i_redirect_e     (redirect_e),
        .i_redirect_pc_e  (redirect_pc_e),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_resp_valid(imem_resp_valid),
        .i_imem_resp_data (imem_resp_data),
        .o_instr_f        (instr_f),
        .o_pc_f           (pc_f),
        .o_pc_plus4_f     (pc_plus4_f),
        .o_instr_valid_f  (instr_valid_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a ^ 32'hA5A5_0013) + 32'd7;
    endfunction

    // memory: lat = number of edges from handshake to the edge that samples the response
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pend        <= 1'b0;
            mem_cnt         <= 0;
            mem_addr        <= '0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            imem_resp_valid <= 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_f(mem_addr);
                    mem_pend        <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (lat == 1) begin
                    imem_resp_valid <= 1'b1;
                    imem_resp_data  <= mem_f(imem_req_addr);
                end else begin
                    mem_pend <= 1'b1;
                    mem_cnt  <= lat - 1;
                    mem_addr <= imem_req_addr;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid_f && !stall_d) begin
                if (exp_cons.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL cons_unexpected: observed pc %h, expected no instruction", pc_f);
                end else begin
                    mon_e = exp_cons.pop_front();
                    chk("cons_pc", pc_f, mon_e);
                    chk("cons_instr", instr_f, mem_f(mon_e));
                    chk("cons_pc_plus4", pc_plus4_f, mon_e + 32'd4);
                end
                cons_prev = cons_last;
                cons_last = cyc;
            end
            if (imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL req_unexpected: observed addr %h, expected no request", imem_req_addr);
                end else begin
                    mon_e = exp_req.pop_front();
                    chk("req_addr", imem_req_addr, mon_e);
                end
            end
        end
    end

    // Advance to 1 time unit after edge Ek, where E0 is the first edge after reset release.
    task automatic run_to(input int k);
        while (cyc < base + k + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        stall_d = 1'b0;
        redirect_e = 1'b0;
        imem_req_ready = 1'b1;
        lat = 1;
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid_f), 32'd0);
        chk("rst_instr_f", instr_f, 32'd0);
        chk("rst_pc_f", pc_f, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = cyc;
        #1;
        chk("idle_no_req", 32'(imem_req_valid), 32'd0);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({tag, "_cons_left"}, 32'(exp_cons.size()), 32'd0);
        exp_req.delete();
        exp_cons.delete();
    endtask

    initial begin
        // 1: zero-wait streaming
        reset_dut();
        exp_req  = '{32'h0, 32'h4, 32'h8};
        exp_cons = '{32'h0, 32'h4, 32'h8};
        run_to(0);
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        run_to(6);
        imem_req_ready = 1'b0;
        run_to(8);
        chk("t1_throughput", 32'(cons_last - cons_prev), 32'd2);
        drained("t1");

        // 2: decode stall pushes the 0x8 response into the skid buffer
        reset_dut();
        exp_req  = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_cons = '{32'h0, 32'h4, 32'h8, 32'hC};
        run_to(4);
        stall_d = 1'b1;
        run_to(6);
        chk("t2_hold_no_req", 32'(imem_req_valid), 32'd0);
        chk("t2_hold_pc_f", pc_f, 32'h4);
        run_to(7);
        chk("t2_hold_still_no_req", 32'(imem_req_valid), 32'd0);
        run_to(8);
        stall_d = 1'b0;
        run_to(9);
        chk("t2_skid_pc_f", pc_f, 32'h8);
        chk("t2_skid_valid", 32'(instr_valid_f), 32'd1);
        chk("t2_next_req_addr", imem_req_addr, 32'hC);
        run_to(10);
        imem_req_ready = 1'b0;
        run_to(13);
        drained("t2");

        // 3: redirect in WAIT coinciding with the 0x8 response
        reset_dut();
        exp_req  = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_cons = '{32'h0, 32'h4, 32'h100};
        run_to(5);
        redirect_e = 1'b1;
        redirect_pc_e = 32'h100;
        run_to(6);
        redirect_e = 1'b0;
        chk("t3_discard_valid", 32'(instr_valid_f), 32'd0);
        chk("t3_new_req_addr", imem_req_addr, 32'h100);
        run_to(7);
        imem_req_ready = 1'b0;
        run_to(8);
        chk("t3_target_pc_f", pc_f, 32'h100);
        run_to(10);
        drained("t3");

        // 3b: redirect in WAIT before a slow response arrives: kill path
        reset_dut();
        lat = 3;
        exp_req  = '{32'h0, 32'h40};
        exp_cons = '{32'h40};
        run_to(1);
        redirect_e = 1'b1;
        redirect_pc_e = 32'h40;
        run_to(2);
        redirect_e = 1'b0;
        run_to(4);
        chk("t3b_killed_valid", 32'(instr_valid_f), 32'd0);
        chk("t3b_new_req_addr", imem_req_addr, 32'h40);
        run_to(5);
        imem_req_ready = 1'b0;
        run_to(8);
        chk("t3b_target_pc_f", pc_f, 32'h40);
        run_to(10);
        drained("t3b");

        // 4: redirect with unaligned target in the same cycle as the 0xC handshake
        reset_dut();
        exp_req  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200};
        exp_cons = '{32'h0, 32'h4, 32'h8, 32'h200};
        run_to(6);
        redirect_e = 1'b1;
        redirect_pc_e = 32'h203;
        run_to(7);
        redirect_e = 1'b0;
        chk("t4_wait_no_req", 32'(imem_req_valid), 32'd0);
        run_to(8);
        chk("t4_killed_valid", 32'(instr_valid_f), 32'd0);
        chk("t4_new_req_addr", imem_req_addr, 32'h200);
        run_to(9);
        imem_req_ready = 1'b0;
        run_to(12);
        drained("t4");

        // 5: back-to-back redirects, last one to the top of the address space
        reset_dut();
        imem_req_ready = 1'b0;
        redirect_e = 1'b1;
        redirect_pc_e = 32'h500;
        exp_req  = '{32'hFFFF_FFFC, 32'h0};
        exp_cons = '{32'hFFFF_FFFC, 32'h0};
        run_to(0);
        chk("t5_first_target", imem_req_addr, 32'h500);
        redirect_pc_e = 32'hFFFF_FFFC;
        run_to(1);
        chk("t5_last_target_wins", imem_req_addr, 32'hFFFF_FFFC);
        redirect_e = 1'b0;
        imem_req_ready = 1'b1;
        run_to(3);
        chk("t5_wrap_pc_plus4", pc_plus4_f, 32'h0);
        run_to(4);
        imem_req_ready = 1'b0;
        run_to(7);
        drained("t5");

        // 6: asynchronous reset while holding a skid entry
        reset_dut();
        exp_req  = '{32'h0, 32'h4, 32'h8};
        exp_cons = '{32'h0};
        run_to(4);
        stall_d = 1'b1;
        run_to(6);
        chk("t6_pre_valid", 32'(instr_valid_f), 32'd1);
        chk("t6_pre_pc_f", pc_f, 32'h4);
        drained("t6a");
        reset_dut();
        exp_req  = '{32'h0};
        exp_cons = '{32'h0};
        run_to(0);
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        run_to(1);
        imem_req_ready = 1'b0;
        run_to(4);
        drained("t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
